// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window on the data bus,
// TX FIFO feeding a start/data/stop serialiser. Register reads are combinational.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_wr_mask,
    output logic [31:0] dmem_rdata,
    output logic        sel,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [AW:0]    r_wptr, r_rptr;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic           r_ovf, r_tx_en;
    logic [1:0]     r_state;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;

    logic           w_wr, w_wr_data, w_wr_status, w_wr_ctrl;
    logic [AW:0]    w_count;
    logic [7:0]     w_count8;
    logic           w_empty, w_full, w_busy, w_baud_done;
    logic           w_pop, w_push, w_shift_adv;
    logic [7:0]     w_head;
    logic           w_unused;

    assign sel         = (dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = sel & dmem_wen & dmem_wr_mask[0];
    assign w_wr_data   = w_wr && (dmem_addr[3:2] == 2'd0);
    assign w_wr_status = w_wr && (dmem_addr[3:2] == 2'd1);
    assign w_wr_ctrl   = w_wr && (dmem_addr[3:2] == 2'd2);
    assign w_unused    = ^{dmem_wdata[31:8], dmem_addr[1:0], dmem_wr_mask[3:1]};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_count  = r_wptr - r_rptr;
    assign w_count8 = 8'(w_count);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    assign w_busy      = (r_state != ST_IDLE);
    assign w_baud_done = (r_baud == BAUD_LAST);
    // Popping at the end of STOP lets the next start bit follow with no gap.
    assign w_pop       = !w_empty && r_tx_en &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));
    assign w_push      = w_wr_data && (!w_full || w_pop);
    assign w_shift_adv = (r_state == ST_DATA) && w_baud_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
            r_tx_en <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_wr_status)
                r_ovf <= 1'b0;
            else if (w_wr_data && w_full && !w_pop)
                r_ovf <= 1'b1;
            if (w_wr_ctrl) r_tx_en <= dmem_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (w_pop)
            r_shift <= w_head;
        else if (w_shift_adv)
            r_shift <= {1'b0, r_shift[7:1]};
    end

    // tx is loaded with the level of the state being entered, so it stays registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx = r_tx;

    always_comb begin
        dmem_rdata = 32'h0;
        if (sel) begin
            case (dmem_addr[3:2])
                2'd1:    dmem_rdata = {16'h0, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
                2'd2:    dmem_rdata = {31'h0, r_tx_en};
                default: dmem_rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4 and an 8-entry FIFO.
module tb_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_wen = 1'b0;
    logic [3:0]  dmem_wr_mask = '0;
    logic [31:0] dmem_rdata;
    logic        sel;
    logic        tx;

    int errors = 0;
    int checks = 0;

    uart_tx_mmio #(.BASE_ADDR(32'h0000_1000), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wen(dmem_wen), .dmem_wr_mask(dmem_wr_mask), .dmem_rdata(dmem_rdata),
        .sel(sel), .tx(tx)
    );

    always #5 clk = ~clk;

    // Expected line level k cycles after the start bit begins (CLK_DIV=4).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k < 4) return 1'b0;
        if (k < 36) return b[(k - 4) / 4];
        return 1'b1;
    endfunction

    // Store on the next edge; returns 1 time unit after that edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dmem_addr = a; dmem_wdata = d; dmem_wr_mask = m; dmem_wen = 1'b1;
        @(posedge clk); #1;
        dmem_wen = 1'b0; dmem_wr_mask = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        dmem_addr = a; dmem_wen = 1'b0;
        #1;
        d = dmem_rdata;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", rd); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b want 1", sel); end
        bus_read(32'h1008, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h want 00000001", rd); end
        bus_read(32'h1000, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", rd); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        int bad;
        bus_write(32'h1000, 32'hFFFF_FFA5, 4'h1);
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL frame_queued_status: got %h want 00000100", rd); end
        step();
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0006) begin errors++; $display("FAIL frame_busy_status: got %h want 00000006", rd); end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (tx !== exp_bit(8'hA5, k)) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL frame_a5_bit k=%0d: got %b want %b", k, tx, exp_bit(8'hA5, k));
            end
            step();
        end
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL frame_done_status: got %h want 00000002", rd); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_overflow_back_to_back();
        logic [31:0] rd;
        logic [7:0] b;
        int bad;
        bus_write(32'h1008, 32'h0, 4'h1);
        for (int i = 0; i < 9; i++) bus_write(32'h1000, 32'h10 + i, 4'h1);
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0809) begin errors++; $display("FAIL ovf_status: got %h want 00000809", rd); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ovf_tx_idle: got %b want 1", tx); end
        bus_write(32'h1004, 32'h0, 4'h1);
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0801) begin errors++; $display("FAIL ovf_clear: got %h want 00000801", rd); end
        bus_write(32'h1008, 32'h1, 4'h1);
        step();
        bad = 0;
        for (int k = 0; k < 320; k++) begin
            b = 8'h10 + 8'(k / 40);
            checks++;
            if (tx !== exp_bit(b, k % 40)) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL b2b_bit k=%0d: got %b want %b", k, tx, exp_bit(b, k % 40));
            end
            step();
        end
        bad = 0;
        for (int k = 0; k < 44; k++) begin
            checks++;
            if (tx !== 1'b1) begin
                errors++; bad++;
                if (bad < 3) $display("FAIL ninth_byte_lost k=%0d: got %b want 1", k, tx);
            end
            step();
        end
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL b2b_done_status: got %h want 00000002", rd); end
    endtask

    task automatic test_txen_midframe();
        logic [31:0] rd;
        int bad;
        bus_write(32'h1000, 32'h3C, 4'h1);
        bus_write(32'h1000, 32'hC3, 4'h1);
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0104) begin errors++; $display("FAIL mid_status: got %h want 00000104", rd); end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tx !== exp_bit(8'h3C, k)) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL mid_bit k=%0d: got %b want %b", k, tx, exp_bit(8'h3C, k));
            end
            step();
        end
        bus_write(32'h1008, 32'h0, 4'h1);
        for (int k = 17; k < 40; k++) begin
            checks++;
            if (tx !== exp_bit(8'h3C, k)) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL mid_finish k=%0d: got %b want %b", k, tx, exp_bit(8'h3C, k));
            end
            step();
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (tx !== 1'b1) begin
                errors++; bad++;
                if (bad < 3) $display("FAIL mid_held k=%0d: got %b want 1", k, tx);
            end
            step();
        end
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL mid_count: got %h want 00000100", rd); end
        bus_read(32'h1008, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_ctrl: got %h want 00000000", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        dmem_addr = 32'h2000; dmem_wdata = 32'h55; dmem_wr_mask = 4'h1; dmem_wen = 1'b1;
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL decode_sel: got %b want 0", sel); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL decode_rdata: got %h want 0", dmem_rdata); end
        @(posedge clk); #1;
        dmem_wen = 1'b0; dmem_wr_mask = 4'h0;
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL decode_count: got %h want 00000100", rd); end
        bus_write(32'h1000, 32'h66, 4'b0010);
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL mask_count: got %h want 00000100", rd); end
        bus_write(32'h100C, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h100C, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want 0", rd); end
        bus_read(32'h1007, rd);
        checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL low_addr_ignored: got %h want 00000100", rd); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        int bad;
        bus_write(32'h1000, 32'h77, 4'h1);
        bus_write(32'h1008, 32'h1, 4'h1);
        step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_start_bit: got %b want 0", tx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        bus_read(32'h1004, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rst_status: got %h want 00000002", rd); end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (tx !== 1'b1) begin
                errors++; bad++;
                if (bad < 3) $display("FAIL rst_no_frames k=%0d: got %b want 1", k, tx);
            end
            step();
        end
        bus_read(32'h1008, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_ctrl: got %h want 00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_txen_midframe();
        test_decode();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
